storage_req_arbiter: RTL and testbench
======================================

Name: storage_req_arbiter

Overview:
- Upstream neighbour of storage_controller: merges the core's instruction-fetch port (read-only) and data port into the single request interface memory_access/addr/d_in/mem_be/out_valid/d_out.
- Round-robin arbitration, byte-to-word address translation, region decode selecting external QSPI storage vs. SRAM (external_storage_access), error responses, and a completion timeout.
- One transaction in flight at a time.

Parameters:
- EXT_REGION, 4'h0, byte_addr[31:28] value mapping to external QSPI storage (read-only).
- SRAM_REGION, 4'h1, byte_addr[31:28] value mapping to on-chip SRAM.
- TIMEOUT, 1024, maximum ACCESS cycles before an error response; counter width $clog2(TIMEOUT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr_req  in  1  instruction fetch request.
- instr_addr  in  32  byte address.
- instr_gnt  out  1  request accepted.
- instr_rvalid  out  1  response pulse.
- instr_rdata  out  32  read data.
- instr_err  out  1  error, valid with instr_rvalid.
- data_req  in  1  data request.
- data_we  in  1  write enable.
- data_addr  in  32  byte address.
- data_be  in  4  byte enables.
- data_wdata  in  32  write data.
- data_gnt  out  1  request accepted.
- data_rvalid  out  1  response pulse.
- data_rdata  out  32  read data.
- data_err  out  1  error, valid with data_rvalid.
- memory_access  out  1  downstream request, held until completion.
- memory_is_writing  out  1  downstream write.
- addr  out  32  downstream word address.
- d_in  out  32  downstream write data.
- mem_be  out  4  downstream byte enables.
- external_storage_access  out  1  selects QSPI storage.
- d_out  in  32  downstream read data.
- out_valid  in  1  downstream completion pulse (reads and writes).

Behaviour:
- Reset: all outputs 0. State IDLE, timeout counter 0, round-robin pointer favours instr first.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - gnt is combinational from req in this state only.
  - Single requester: granted.
  - Both requesting: grant the port not granted last; pointer updates on each grant.
  - The grant cycle latches addr/we/be/wdata and winner id. instr requests always have we=0 and be=4'hF.
- Decode of byte_addr[31:28]:
  - EXT_REGION read: ACCESS with external_storage_access=1.
  - SRAM_REGION read or write: ACCESS with external_storage_access=0.
  - EXT_REGION write, or any other region: no downstream access; go to RESP with err=1 and rdata=0.
- Downstream address: addr = {6'b0, byte_addr[27:2]}. byte_addr[1:0] is ignored.
- ACCESS:
  - memory_access=1. memory_is_writing, addr, d_in, mem_be and external_storage_access come from latched registers and are stable throughout.
  - Counter increments each cycle.
  - out_valid=1: latch d_out (0 for writes), err=0, go to RESP.
  - Counter reaches TIMEOUT-1 with out_valid=0: err=1, rdata=0, go to RESP.
  - out_valid in the same cycle as the timeout: success wins.
- RESP:
  - memory_access=0.
  - Winner's rvalid=1 for exactly one cycle with rdata/err. Other port's rvalid=0.
  - Counter clears. Next state IDLE.
- Downstream turnaround: memory_access is low for at least 2 cycles between transactions (RESP + IDLE).
- Latency: grant at cycle 0; memory_access cycles 1..k; out_valid at k; rvalid at k+1.
- Error path: grant at 0, rvalid/err at 1.
- out_valid outside ACCESS is ignored.
- rdata/err are held between responses; they are meaningful only with rvalid.
- Requests are never granted outside IDLE; requesters hold req until gnt.
- Reset mid-operation:
  - memory_access drops at the reset edge.
  - No rvalid for the aborted transaction.
  - Pointer returns to instr-first.

Test Plan:
- instr_req, addr 0x0000_0010, stub returns 0xDEAD_BEEF after 5 cycles -> instr_gnt at cycle 0; addr=0x4 with external_storage_access=1 for cycles 1-5; instr_rvalid at 6 with rdata 0xDEAD_BEEF, err=0.
- data write to 0x1000_0008, wdata 0x1234_5678, be 4'hF; then read of the same address -> downstream addr=0x2, memory_is_writing=1 then 0; data_rvalid on both; read returns 0x1234_5678.
- Both ports request continuously from reset -> grants alternate instr, data, instr, data; memory_access low ≥2 cycles between transactions.
- data write to 0x0000_0004 (external) and read of 0x3000_0000 -> no memory_access; data_rvalid next cycle with err=1, rdata=0.
- Read with out_valid never asserted, TIMEOUT=16 -> memory_access high 16 cycles; rvalid with err=1; next request serviced normally.
- rst asserted in cycle 3 of an ACCESS -> memory_access=0 next cycle, no rvalid; a post-reset simultaneous request grants instr first.

Source files
------------

// File: rtl/storage_req_arbiter.sv
// Merges the instruction-fetch and data ports into one downstream memory request interface.
// Round-robin grant, region decode, word-address translation and a completion timeout.
module storage_req_arbiter #(
   parameter logic [3:0]  EXT_REGION  = 4'h0,
   parameter logic [3:0]  SRAM_REGION = 4'h1,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic        clk,
   input  logic        rst,
   // instruction fetch port
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_gnt,
   output logic        instr_rvalid,
   output logic [31:0] instr_rdata,
   output logic        instr_err,
   // data port
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        data_err,
   // downstream
   output logic        memory_access,
   output logic        memory_is_writing,
   output logic [31:0] addr,
   output logic [31:0] d_in,
   output logic [3:0]  mem_be,
   output logic        external_storage_access,
   input  logic [31:0] d_out,
   input  logic        out_valid
);

   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          prefer_data_q, prefer_data_d;
   logic          winner_q, winner_d;   // 1: data port owns the transaction
   logic          we_q, we_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          ext_q, ext_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   req_addr;
   logic          req_we;
   logic [3:0]    region;

   // byte offset within a word never reaches the downstream interface
   logic unused_byte_offset;
   assign unused_byte_offset = ^{instr_addr[1:0], data_addr[1:0]};

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      prefer_data_d = prefer_data_q;
      winner_d      = winner_q;
      we_d          = we_q;
      be_d          = be_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      ext_d         = ext_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      instr_gnt     = 1'b0;
      data_gnt      = 1'b0;
      req_addr      = '0;
      req_we        = 1'b0;
      region        = '0;

      unique case (state_q)
         StIdle: begin
            instr_gnt = instr_req && (!data_req || !prefer_data_q);
            data_gnt  = data_req && (!instr_req || prefer_data_q);
            if (instr_gnt || data_gnt) begin
               req_addr      = data_gnt ? data_addr : instr_addr;
               req_we        = data_gnt && data_we;
               region        = req_addr[31:28];
               winner_d      = data_gnt;
               prefer_data_d = instr_gnt;
               we_d          = req_we;
               be_d          = data_gnt ? data_be : 4'hF;
               wdata_d       = data_gnt ? data_wdata : '0;
               addr_d        = {6'b0, req_addr[27:2]};
               if (region == EXT_REGION && !req_we) begin
                  ext_d   = 1'b1;
                  state_d = StAccess;
               end else if (region == SRAM_REGION) begin
                  ext_d   = 1'b0;
                  state_d = StAccess;
               end else begin
                  // external storage is read-only; unmapped regions error out immediately
                  ext_d   = 1'b0;
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = StResp;
               end
            end
         end
         StAccess: begin
            cnt_d = cnt_q + CW'(1);
            if (out_valid) begin
               rdata_d = we_q ? '0 : d_out;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         prefer_data_q <= 1'b0;
         winner_q      <= 1'b0;
         we_q          <= 1'b0;
         be_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         ext_q         <= 1'b0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         prefer_data_q <= prefer_data_d;
         winner_q      <= winner_d;
         we_q          <= we_d;
         be_q          <= be_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         ext_q         <= ext_d;
         rdata_q       <= rdata_d;
         err_q         <= err_d;
      end
   end

   assign memory_access           = (state_q == StAccess);
   assign memory_is_writing       = we_q;
   assign addr                    = addr_q;
   assign d_in                    = wdata_q;
   assign mem_be                  = be_q;
   assign external_storage_access = ext_q;

   assign instr_rvalid = (state_q == StResp) && !winner_q;
   assign data_rvalid  = (state_q == StResp) && winner_q;
   assign instr_rdata  = rdata_q;
   assign data_rdata   = rdata_q;
   assign instr_err    = err_q;
   assign data_err     = err_q;

endmodule

// File: tb/tb_storage_req_arbiter.sv
// Directed bench for storage_req_arbiter: latency, write/read, alternation, error,
// timeout and mid-transaction reset, with the downstream memory driven by hand.
module tb_storage_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_rdata;
   logic        data_req, data_we;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_be;
   logic        data_gnt, data_rvalid, data_err;
   logic [31:0] data_rdata;
   logic        memory_access, memory_is_writing, external_storage_access;
   logic [31:0] addr, d_in, d_out;
   logic [3:0]  mem_be;
   logic        out_valid;

   int n_cmp = 0;
   int n_mis = 0;

   storage_req_arbiter #(
      .EXT_REGION (4'h0),
      .SRAM_REGION(4'h1),
      .TIMEOUT    (16)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .instr_req              (instr_req),
      .instr_addr             (instr_addr),
      .instr_gnt              (instr_gnt),
      .instr_rvalid           (instr_rvalid),
      .instr_rdata            (instr_rdata),
      .instr_err              (instr_err),
      .data_req               (data_req),
      .data_we                (data_we),
      .data_addr              (data_addr),
      .data_be                (data_be),
      .data_wdata             (data_wdata),
      .data_gnt               (data_gnt),
      .data_rvalid            (data_rvalid),
      .data_rdata             (data_rdata),
      .data_err               (data_err),
      .memory_access          (memory_access),
      .memory_is_writing      (memory_is_writing),
      .addr                   (addr),
      .d_in                   (d_in),
      .mem_be                 (mem_be),
      .external_storage_access(external_storage_access),
      .d_out                  (d_out),
      .out_valid              (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change at the negedge, outputs are checked 1 time unit later
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; instr_req = 0; instr_addr = '0; data_req = 0; data_we = 0;
      data_addr = '0; data_be = '0; data_wdata = '0; d_out = '0; out_valid = 0;
      tick(); tick();
      #1;
      chk("rst_maccess", memory_access, 0);
      chk("rst_addr", addr, 0);
      chk("rst_ext", external_storage_access, 0);
      chk("rst_irvalid", instr_rvalid, 0);
      chk("rst_drvalid", data_rvalid, 0);
      chk("rst_irdata", instr_rdata, 0);
      tick(); rst = 1'b0;

      // instruction fetch from external storage, completion after 5 cycles
      tick(); instr_req = 1; instr_addr = 32'h0000_0010; #1;
      chk("t1_igrant", instr_gnt, 1);
      chk("t1_dgrant", data_gnt, 0);
      tick(); instr_req = 0; #1;
      chk("t1_maccess", memory_access, 1);
      chk("t1_addr", addr, 32'h4);
      chk("t1_ext", external_storage_access, 1);
      chk("t1_we", memory_is_writing, 0);
      chk("t1_be", mem_be, 4'hF);
      for (int c = 2; c <= 4; c++) begin
         tick(); #1;
         chk("t1_hold", memory_access, 1);
      end
      tick(); out_valid = 1; d_out = 32'hDEAD_BEEF; #1;
      chk("t1_c5_maccess", memory_access, 1);
      tick(); out_valid = 0; d_out = '0; #1;
      chk("t1_irvalid", instr_rvalid, 1);
      chk("t1_irdata", instr_rdata, 32'hDEAD_BEEF);
      chk("t1_ierr", instr_err, 0);
      chk("t1_drvalid", data_rvalid, 0);
      chk("t1_resp_maccess", memory_access, 0);
      tick(); #1;
      chk("t1_irvalid_pulse", instr_rvalid, 0);

      // SRAM write then read back of the same word
      data_req = 1; data_we = 1; data_addr = 32'h1000_0008; data_be = 4'hF;
      data_wdata = 32'h1234_5678; #1;
      chk("t2w_dgrant", data_gnt, 1);
      tick(); data_req = 0; #1;
      chk("t2w_maccess", memory_access, 1);
      chk("t2w_we", memory_is_writing, 1);
      chk("t2w_addr", addr, 32'h2);
      chk("t2w_din", d_in, 32'h1234_5678);
      chk("t2w_ext", external_storage_access, 0);
      tick(); out_valid = 1; d_out = 32'hFFFF_FFFF; #1;
      tick(); out_valid = 0; #1;
      chk("t2w_drvalid", data_rvalid, 1);
      chk("t2w_derr", data_err, 0);
      chk("t2w_drdata", data_rdata, 0);
      tick(); data_req = 1; data_we = 0; #1;
      chk("t2r_dgrant", data_gnt, 1);
      tick(); data_req = 0; #1;
      chk("t2r_we", memory_is_writing, 0);
      chk("t2r_addr", addr, 32'h2);
      tick(); out_valid = 1; d_out = 32'h1234_5678; #1;
      tick(); out_valid = 0; d_out = '0; #1;
      chk("t2r_drvalid", data_rvalid, 1);
      chk("t2r_drdata", data_rdata, 32'h1234_5678);

      // both ports requesting continuously: grants alternate starting with instr
      for (int t = 0; t < 4; t++) begin
         tick(); instr_req = 1; instr_addr = 32'h0000_0020;
         data_req = 1; data_we = 0; data_addr = 32'h1000_0000; #1;
         chk("t3_igrant", instr_gnt, (t % 2 == 0) ? 1 : 0);
         chk("t3_dgrant", data_gnt, (t % 2 == 1) ? 1 : 0);
         chk("t3_gap_idle", memory_access, 0);
         tick(); out_valid = 1; d_out = 32'hA000_0000 + t; #1;
         chk("t3_maccess", memory_access, 1);
         chk("t3_no_gnt", {instr_gnt, data_gnt}, 0);
         tick(); out_valid = 0; #1;
         chk("t3_gap_resp", memory_access, 0);
         chk("t3_irvalid", instr_rvalid, (t % 2 == 0) ? 1 : 0);
         chk("t3_drvalid", data_rvalid, (t % 2 == 1) ? 1 : 0);
         chk("t3_rdata", (t % 2 == 0) ? instr_rdata : data_rdata, 32'hA000_0000 + t);
      end

      // error responses: write to external storage, read of unmapped region
      tick(); instr_req = 0; data_req = 1; data_we = 1; data_addr = 32'h0000_0004; #1;
      chk("t4w_dgrant", data_gnt, 1);
      tick(); data_req = 0; #1;
      chk("t4w_maccess", memory_access, 0);
      chk("t4w_drvalid", data_rvalid, 1);
      chk("t4w_derr", data_err, 1);
      chk("t4w_drdata", data_rdata, 0);
      tick(); data_req = 1; data_we = 0; data_addr = 32'h3000_0000; #1;
      chk("t4r_dgrant", data_gnt, 1);
      tick(); data_req = 0; #1;
      chk("t4r_maccess", memory_access, 0);
      chk("t4r_drvalid", data_rvalid, 1);
      chk("t4r_derr", data_err, 1);
      chk("t4r_drdata", data_rdata, 0);

      // timeout after 16 access cycles, then a normal fetch
      tick(); data_req = 1; data_addr = 32'h1000_0010; #1;
      chk("t5_dgrant", data_gnt, 1);
      for (int c = 1; c <= 16; c++) begin
         tick(); data_req = 0; #1;
         chk("t5_maccess", memory_access, 1);
      end
      tick(); #1;
      chk("t5_to_maccess", memory_access, 0);
      chk("t5_drvalid", data_rvalid, 1);
      chk("t5_derr", data_err, 1);
      chk("t5_drdata", data_rdata, 0);
      tick(); instr_req = 1; instr_addr = 32'h0000_0040; #1;
      chk("t5n_igrant", instr_gnt, 1);
      tick(); instr_req = 0; out_valid = 1; d_out = 32'hCAFE_F00D; #1;
      chk("t5n_addr", addr, 32'h10);
      tick(); out_valid = 0; d_out = '0; #1;
      chk("t5n_irvalid", instr_rvalid, 1);
      chk("t5n_irdata", instr_rdata, 32'hCAFE_F00D);
      chk("t5n_ierr", instr_err, 0);

      // reset in access cycle 3 aborts silently and restores instr-first priority
      tick(); instr_req = 1; instr_addr = 32'h0000_0100; #1;
      chk("t6_igrant", instr_gnt, 1);
      tick(); instr_req = 0;
      tick();
      tick(); rst = 1; #1;
      chk("t6_pre_rst_maccess", memory_access, 1);
      tick(); rst = 0; instr_req = 1; data_req = 1; data_we = 0; data_addr = 32'h1000_0000; #1;
      chk("t6_maccess", memory_access, 0);
      chk("t6_irvalid", instr_rvalid, 0);
      chk("t6_drvalid", data_rvalid, 0);
      chk("t6_igrant", instr_gnt, 1);
      chk("t6_dgrant", data_gnt, 0);
      tick(); instr_req = 0; data_req = 0; #1;
      chk("t6_post_maccess", memory_access, 1);
      chk("t6_post_addr", addr, 32'h40);
      tick(); out_valid = 1; d_out = 32'h0000_0001; #1;
      tick(); out_valid = 0; #1;
      chk("t6_post_irvalid", instr_rvalid, 1);
      chk("t6_post_drvalid", data_rvalid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
